// File: rtl/note_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : note_tone_gen
// Purpose  : Latches a 4-bit note code on each rising edge of the quarter-beat
//            strobe and drives a 50%-duty square wave at that note's pitch.
//            Phase runs continuously while the same note is held across beats.
// Ports    : CLK            main clock (rising edge)
//            RESET_N        asynchronous active-low reset
//            _QUARTER_BEAT  beat strobe, asynchronous to CLK
//            NOTE[3:0]      note code (0=C5 .. 7=C4, 8=none, 9-15 invalid)
//            MUTE           level, forces SPK low without disturbing phase
//            SPK            square-wave audio output (registered)
//            PLAYING        high while a valid pitch is latched
//            CUR_NOTE[3:0]  currently latched note code
// Revision : 1.0 - initial release
// ============================================================================
module note_tone_gen #(
  parameter int CLK_HZ = 100000000,
  parameter int CNT_W  = 18
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       _QUARTER_BEAT,
  input  logic [3:0] NOTE,
  input  logic       MUTE,
  output logic       SPK,
  output logic       PLAYING,
  output logic [3:0] CUR_NOTE
);

  // Terminal counts (HALF - 1), HALF = round(CLK_HZ / (2*f)).
  localparam logic [CNT_W-1:0] c_TERM_C5 = CNT_W'((CLK_HZ + 523) / (2 * 523) - 1);
  localparam logic [CNT_W-1:0] c_TERM_B  = CNT_W'((CLK_HZ + 494) / (2 * 494) - 1);
  localparam logic [CNT_W-1:0] c_TERM_A  = CNT_W'((CLK_HZ + 440) / (2 * 440) - 1);
  localparam logic [CNT_W-1:0] c_TERM_G  = CNT_W'((CLK_HZ + 392) / (2 * 392) - 1);
  localparam logic [CNT_W-1:0] c_TERM_F  = CNT_W'((CLK_HZ + 349) / (2 * 349) - 1);
  localparam logic [CNT_W-1:0] c_TERM_E  = CNT_W'((CLK_HZ + 330) / (2 * 330) - 1);
  localparam logic [CNT_W-1:0] c_TERM_D  = CNT_W'((CLK_HZ + 294) / (2 * 294) - 1);
  localparam logic [CNT_W-1:0] c_TERM_C4 = CNT_W'((CLK_HZ + 262) / (2 * 262) - 1);

  localparam logic [3:0] c_NOTE_NONE = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_TONE = 1'b1
  } state_t;

  // Synchronisers
  logic       r_b1, r_b2, r_b3;
  logic [3:0] r_n1, r_n2;
  logic       r_primed;
  logic       r_armed;
  logic       w_tick;

  // Tone state
  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cur_note, w_note_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_phase, w_phase_nxt;
  logic             r_spk;
  logic [CNT_W-1:0] w_term;

  // r_armed suppresses a spurious tick when the beat is already high at
  // reset release: ticks are only accepted once the beat has been observed
  // low at least one full cycle after release (r_primed marks that r_b1
  // holds a genuine post-reset sample).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_b1     <= 1'b0;
      r_b2     <= 1'b0;
      r_b3     <= 1'b0;
      r_n1     <= 4'd0;
      r_n2     <= 4'd0;
      r_primed <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_b1     <= _QUARTER_BEAT;
      r_b2     <= r_b1;
      r_b3     <= r_b2;
      r_n1     <= NOTE;
      r_n2     <= r_n1;
      r_primed <= 1'b1;
      r_armed  <= r_armed | (r_primed & ~r_b1);
    end
  end

  assign w_tick = r_b2 & ~r_b3 & r_armed;

  always_comb begin
    w_term = c_TERM_C4;
    case (r_cur_note)
      4'd0:    w_term = c_TERM_C5;
      4'd1:    w_term = c_TERM_B;
      4'd2:    w_term = c_TERM_A;
      4'd3:    w_term = c_TERM_G;
      4'd4:    w_term = c_TERM_F;
      4'd5:    w_term = c_TERM_E;
      4'd6:    w_term = c_TERM_D;
      default: w_term = c_TERM_C4;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_IDLE;
      r_cur_note <= c_NOTE_NONE;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_spk      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_note <= w_note_nxt;
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      // Built from the current phase, so SPK lags phase by one cycle.
      r_spk      <= r_phase & (r_state == ST_TONE) & ~MUTE;
    end
  end

  // A tick takes priority over the terminal count; when the tick holds the
  // same note it falls through to the counting branch so the toggle still
  // happens and the waveform stays continuous.
  always_comb begin
    w_state_nxt = r_state;
    w_note_nxt  = r_cur_note;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (w_tick && r_n2[3]) begin
      w_state_nxt = ST_IDLE;
      w_note_nxt  = c_NOTE_NONE;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else if (w_tick && ((r_n2 != r_cur_note) || (r_state == ST_IDLE))) begin
      w_state_nxt = ST_TONE;
      w_note_nxt  = r_n2;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else if (r_state == ST_TONE) begin
      if (r_cnt == w_term) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end
  end

  assign SPK      = r_spk;
  assign PLAYING  = (r_state == ST_TONE);
  assign CUR_NOTE = r_cur_note;

endmodule
`default_nettype wire
